stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/lap buttons, IDLE/RUN/PAUSE control,
// hundredth-second prescaler and a 4-digit BCD count with a lap freeze register.
module stopwatch_ctrl #(
    parameter int DEB_MS = 8,
    parameter int TDIV   = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ce1ms,
    input  logic        btn_start,
    input  logic        btn_lap,
    output logic [15:0] dat,
    output logic        run,
    output logic        hold,
    output logic        ce_cs,
    output logic        ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [7:0] DEB_LAST  = 8'(DEB_MS - 1);
    localparam logic [7:0] TDIV_LAST = 8'(TDIV - 1);

    logic [1:0]  w_btn_raw;
    logic [1:0]  w_press;
    logic        w_start_p;
    logic        w_lap_p;
    logic        w_tick_cs;
    logic [15:0] w_cnt_inc;
    logic        w_carry;

    logic [1:0]  r_state;
    logic [7:0]  r_presc;
    logic [15:0] r_cnt;
    logic [15:0] r_lap;
    logic [15:0] r_dat;
    logic        r_hold;
    logic        r_ce_cs;
    logic        r_ovf;

    assign w_btn_raw = {btn_lap, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic       r_sync1;
            logic       r_sync2;
            logic       r_lvl;
            logic       r_lvl_d;
            logic [7:0] r_stab;

            // r_stab counts consecutive sampled ticks that disagree with r_lvl
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_lvl_d <= 1'b0;
                    r_stab  <= 8'd0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    r_lvl_d <= r_lvl;
                    if (ce1ms) begin
                        if (r_sync2 != r_lvl) begin
                            if (r_stab == DEB_LAST) begin
                                r_lvl  <= r_sync2;
                                r_stab <= 8'd0;
                            end else begin
                                r_stab <= r_stab + 8'd1;
                            end
                        end else begin
                            r_stab <= 8'd0;
                        end
                    end
                end
            end

            assign w_press[gi] = r_lvl & ~r_lvl_d;
        end
    endgenerate

    assign w_start_p = w_press[0];
    assign w_lap_p   = w_press[1];
    assign w_tick_cs = (r_state == ST_RUN) && ce1ms && (r_presc == TDIV_LAST);

    always_comb begin
        w_cnt_inc = r_cnt;
        w_carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_cnt[4*i +: 4] >= 4'd9) begin
                    w_cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_presc <= 8'd0;
            r_cnt   <= 16'h0000;
            r_lap   <= 16'h0000;
            r_dat   <= 16'h0000;
            r_hold  <= 1'b0;
            r_ce_cs <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ce_cs <= 1'b0;
            r_ovf   <= 1'b0;
            r_dat   <= r_hold ? r_lap : r_cnt;

            if ((r_state == ST_RUN) && ce1ms) begin
                r_presc <= (r_presc == TDIV_LAST) ? 8'd0 : r_presc + 8'd1;
            end
            if (w_tick_cs) begin
                r_cnt   <= w_cnt_inc;
                r_ce_cs <= 1'b1;
                r_ovf   <= w_carry;
            end

            // start wins over a coincident lap press
            case (r_state)
                ST_IDLE: begin
                    if (w_start_p) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_start_p) begin
                        r_state <= ST_PAUSE;
                    end else if (w_lap_p) begin
                        r_hold <= ~r_hold;
                        if (!r_hold) r_lap <= r_cnt;
                    end
                end
                ST_PAUSE: begin
                    if (w_start_p) begin
                        r_state <= ST_RUN;
                    end else if (w_lap_p) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 16'h0000;
                        r_presc <= 8'd0;
                        r_hold  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dat   = r_dat;
    assign run   = (r_state == ST_RUN);
    assign hold  = r_hold;
    assign ce_cs = r_ce_cs;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button activity,
// checked against a tick-level behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

    localparam int DEB = 2;
    localparam int TD  = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        ce1ms = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_lap = 1'b0;
    logic [15:0] dat;
    logic        run;
    logic        hold;
    logic        ce_cs;
    logic        ovf;

    int n_vec  = 0;
    int n_miss = 0;
    int dut_cs_pulses  = 0;
    int dut_ovf_pulses = 0;

    // model: time kept as an integer number of hundredths
    int m_state = 0;        // 0 idle, 1 run, 2 pause
    int m_count = 0;
    int m_presc = 0;
    int m_lap   = 0;
    bit m_hold  = 1'b0;
    bit m_lvl  [2];
    int m_diff [2];
    int m_cs_pulses  = 0;
    int m_ovf_pulses = 0;

    stopwatch_ctrl #(.DEB_MS(DEB), .TDIV(TD)) dut (
        .clk       (clk),
        .clr       (clr),
        .ce1ms     (ce1ms),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .dat       (dat),
        .run       (run),
        .hold      (hold),
        .ce_cs     (ce_cs),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ce_cs) dut_cs_pulses++;
        if (ovf)   dut_ovf_pulses++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ce);
        ce1ms = ce;
        @(posedge clk);
        #1;
        ce1ms = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 0; m_count = 0; m_presc = 0; m_lap = 0; m_hold = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 1'b0;
            m_diff[b] = 0;
        end
    endtask

    task automatic model_tick();
        bit rose [2];
        bit raw  [2];
        raw[0] = btn_start;
        raw[1] = btn_lap;
        if (m_state == 1) begin
            m_presc++;
            if (m_presc == TD) begin
                m_presc = 0;
                m_cs_pulses++;
                m_count = (m_count + 1) % 10000;
                if (m_count == 0) m_ovf_pulses++;
            end
        end
        for (int b = 0; b < 2; b++) begin
            rose[b] = 1'b0;
            if (raw[b] != m_lvl[b]) begin
                m_diff[b]++;
                if (m_diff[b] == DEB) begin
                    m_lvl[b]  = raw[b];
                    m_diff[b] = 0;
                    rose[b]   = raw[b];
                end
            end else begin
                m_diff[b] = 0;
            end
        end
        if (rose[0]) begin
            m_state = (m_state == 1) ? 2 : 1;
        end else if (rose[1]) begin
            if (m_state == 1) begin
                if (!m_hold) m_lap = m_count;
                m_hold = !m_hold;
            end else if (m_state == 2) begin
                m_state = 0; m_count = 0; m_presc = 0; m_hold = 1'b0;
            end
        end
    endtask

    task automatic set_buttons(input bit s, input bit l);
        btn_start = s;
        btn_lap   = l;
        step(1'b0);
        step(1'b0);
    endtask

    task automatic tick();
        step(1'b1);
        model_tick();
        step(1'b0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_all(input string tag);
        step(1'b0);
        chk({tag, ".dat"},  32'(dat),  32'(to_bcd(m_hold ? m_lap : m_count)));
        chk({tag, ".run"},  32'(run),  32'(m_state == 1));
        chk({tag, ".hold"}, 32'(hold), 32'(m_hold));
        chk({tag, ".cs"},   32'(dut_cs_pulses),  32'(m_cs_pulses));
        chk({tag, ".ovf"},  32'(dut_ovf_pulses), 32'(m_ovf_pulses));
        $display("step %-10s dat=%h run=%0d hold=%0d cs=%0d ovf=%0d", tag, dat, run, hold,
                 dut_cs_pulses, dut_ovf_pulses);
    endtask

    task automatic do_clr(input string tag);
        clr = 1'b1;
        step(1'b0);
        chk({tag, ".clr_dat"}, 32'(dat), 32'h0);
        chk({tag, ".clr_out"}, 32'({run, hold, ce_cs, ovf}), 32'h0);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic press_start();
        set_buttons(1'b1, 1'b0);
        ticks(DEB);
        set_buttons(1'b0, 1'b0);
    endtask

    task automatic press_lap();
        set_buttons(1'b0, 1'b1);
        ticks(DEB);
        set_buttons(1'b0, 1'b0);
    endtask

    initial begin
        int guard;
        model_reset();
        step(1'b0);
        do_clr("reset");

        // start then 20 ticks -> 0.10 s
        press_start();
        ticks(20);
        check_all("start20");
        chk("start20.dat_const", 32'(dat), 32'h0010);
        chk("start20.cs_const", 32'(dut_cs_pulses), 32'd10);

        // glitch of one tick is rejected, three ticks give one press
        do_clr("deb");
        set_buttons(1'b1, 1'b0);
        ticks(1);
        set_buttons(1'b0, 1'b0);
        ticks(4);
        check_all("glitch");
        chk("glitch.run_const", 32'(run), 32'd0);
        set_buttons(1'b1, 1'b0);
        ticks(3);
        set_buttons(1'b0, 1'b0);
        ticks(3);
        check_all("bounce3");
        chk("bounce3.run_const", 32'(run), 32'd1);

        // lap freeze at 0.05, release shows live 0.10
        do_clr("lap");
        press_start();
        ticks(8);
        press_lap();
        ticks(8);
        check_all("lapfrz");
        chk("lapfrz.dat_const", 32'(dat), 32'h0005);
        press_lap();
        check_all("laprel");
        chk("laprel.dat_const", 32'(dat), 32'h0010);

        // pause at 0.42, no counting while paused, lap clears to IDLE
        do_clr("pause");
        press_start();
        ticks(82);
        press_start();
        check_all("pause42");
        chk("pause42.dat_const", 32'(dat), 32'h0042);
        ticks(20);
        check_all("paused");
        chk("paused.run_const", 32'(run), 32'd0);
        press_lap();
        check_all("cleared");
        chk("cleared.dat_const", 32'(dat), 32'h0000);

        // wrap 99.99 -> 00.00
        do_clr("wrap");
        press_start();
        guard = 0;
        while (m_count != 9999 && guard < 25000) begin
            tick();
            guard++;
        end
        chk("wrap.reach9999", 32'(m_count), 32'd9999);
        check_all("at9999");
        chk("at9999.dat_const", 32'(dat), 32'h9999);
        ticks(2);
        check_all("wrapped");
        chk("wrapped.dat_const", 32'(dat), 32'h0000);
        chk("wrapped.ovf_const", 32'(dut_ovf_pulses), 32'd1);
        chk("wrapped.run_const", 32'(run), 32'd1);

        // simultaneous start+lap in IDLE, then clear mid-RUN
        do_clr("simul");
        set_buttons(1'b1, 1'b1);
        ticks(DEB);
        set_buttons(1'b0, 1'b0);
        ticks(5);
        check_all("simul");
        chk("simul.state_const", 32'({run, hold}), 32'b10);
        do_clr("midrun");
        check_all("postclr");

        // random button activity
        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 39) == 0) do_clr("rclr");
            set_buttons(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            ticks($urandom_range(1, 4));
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
